// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the datapath and the microcoded control unit.
//   DATA_WIDTH     default datapath/bus width
//   flags_t        registered flag vector (cf, zf and, with ALU_OVF_FLAG_EN, vf)
//   CTL_*          bit positions of the control lines within the microcode word
// Optional feature macro: ALU_OVF_FLAG_EN (adds vf to flags_t).
package cpu_pkg;

  localparam int DATA_WIDTH = 8;

  typedef struct packed {
    logic cf;
    logic zf;
`ifdef ALU_OVF_FLAG_EN
    logic vf;
`endif
  } flags_t;

  // Control-word bit positions; the *_bar lines are active low in the word.
  localparam int CTL_HLT    = 0;
  localparam int CTL_AI_BAR = 1;
  localparam int CTL_AO_BAR = 2;
  localparam int CTL_BI_BAR = 3;
  localparam int CTL_EO_BAR = 4;
  localparam int CTL_SU     = 5;
  localparam int CTL_FI_BAR = 6;
  localparam int CTL_WIDTH  = 7;

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: combinational WIDTH-bit adder/subtractor.
//   a, b    operands
//   su      1 = a - b, 0 = a + b
//   result  WIDTH-bit sum
//   carry   carry out (for subtract: 1 when a >= b, unsigned)
//   ovf     signed overflow (only with ALU_OVF_FLAG_EN)
module alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             su,
  output logic [WIDTH-1:0] result,
  output logic             carry
`ifdef ALU_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;

  // Two's-complement subtract: invert B and inject su as carry-in.
  always_comb begin
    bx  = b ^ {WIDTH{su}};
    sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, su};
  end

  assign result = sum[WIDTH-1:0];
  assign carry  = sum[WIDTH];

`ifdef ALU_OVF_FLAG_EN
  assign ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`endif

endmodule

// File: rtl/alu_flags_unit.sv
// alu_flags_unit: A/B registers, add/subtract ALU and flags register.
//   clk, rst   clock (rising-edge state), synchronous active-high reset
//   hlt        freezes A, B and flags
//   bus_in     resolved bus value
//   ai_bar     load A (active low)      ao_bar  drive A to bus (active low)
//   bi_bar     load B (active low)      eo_bar  drive ALU result (active low)
//   su         1 = subtract             fi_bar  latch flags (active low)
//   bus_out    value driven by this block, bus_oe = drive enable
//   cf, zf     registered carry/zero flags
//   a_dbg      A register contents
//   bus_err    sticky ao/eo contention flag
//   vf         registered signed overflow (only with ALU_OVF_FLAG_EN)
module alu_flags_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hlt,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             ai_bar,
  input  logic             ao_bar,
  input  logic             bi_bar,
  input  logic             eo_bar,
  input  logic             su,
  input  logic             fi_bar,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic             cf,
  output logic             zf,
  output logic [WIDTH-1:0] a_dbg,
  output logic             bus_err
`ifdef ALU_OVF_FLAG_EN
  ,
  output logic             vf
`endif
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  flags_t           flags;
  flags_t           flags_next;
  logic [WIDTH-1:0] result;
  logic             carry;
`ifdef ALU_OVF_FLAG_EN
  logic             ovf;
`endif

  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .su     (su),
    .result (result),
    .carry  (carry)
`ifdef ALU_OVF_FLAG_EN
    ,
    .ovf    (ovf)
`endif
  );

  always_comb begin
    flags_next    = flags;
    flags_next.cf = carry;
    flags_next.zf = (result == '0);
`ifdef ALU_OVF_FLAG_EN
    flags_next.vf = ovf;
`endif
  end

  // A has drive priority when both enables are asserted; that case is
  // also recorded in bus_err.
  always_comb begin
    bus_out = '0;
    if (!ao_bar)
      bus_out = a_reg;
    else if (!eo_bar)
      bus_out = result;
  end

  assign bus_oe = ~ao_bar | ~eo_bar;

  // Flags latch from the pre-edge A/B, so a same-edge A load sees old A.
  // Contention detection ignores hlt; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      flags   <= '0;
      bus_err <= 1'b0;
    end else begin
      if (!ao_bar && !eo_bar)
        bus_err <= 1'b1;
      if (!hlt) begin
        if (!ai_bar) a_reg <= bus_in;
        if (!bi_bar) b_reg <= bus_in;
        if (!fi_bar) flags <= flags_next;
      end
    end
  end

  assign cf    = flags.cf;
  assign zf    = flags.zf;
  assign a_dbg = a_reg;
`ifdef ALU_OVF_FLAG_EN
  assign vf    = flags.vf;
`endif

endmodule
